// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath:
// instruction fields and ALU flag in, mux selects, enables and ALU code out.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         imm_src;
    logic [2:0]         alu_control;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               illegal_op, state_o
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-FSM main controller for the multicycle RV32I core: sequences each
// instruction class and decodes immediate format and ALU operation.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        s_fetch    = 0,
        s_decode   = 1,
        s_memadr   = 2,
        s_memread  = 3,
        s_memwb    = 4,
        s_memwrite = 5,
        s_executer = 6,
        s_executei = 7,
        s_aluwb    = 8,
        s_jal      = 9,
        s_beq      = 10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       pc_update;
    logic       branch;
    logic       op_illegal;
    logic [1:0] alu_op;
    logic       adr_src_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= s_fetch;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        op_illegal = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_IALU, OP_JAL, OP_BEQ: op_illegal = 1'b0;
            default:                                     op_illegal = 1'b1;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = s_fetch;
        pc_update    = 1'b0;
        branch       = 1'b0;
        alu_op       = 2'b00;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        case (state)
            s_fetch: begin
                state_next   = s_decode;
                ir_write_c   = 1'b1;
                pc_update    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
            end
            s_decode: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_next = s_memadr;
                    OP_R:         state_next = s_executer;
                    OP_IALU:      state_next = s_executei;
                    OP_JAL:       state_next = s_jal;
                    OP_BEQ:       state_next = s_beq;
                    default:      state_next = s_fetch;
                endcase
            end
            s_memadr: begin
                state_next  = (bus.op == OP_LW) ? s_memread : s_memwrite;
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
            end
            s_memread: begin
                state_next = s_memwb;
                adr_src_c  = 1'b1;
            end
            s_memwb: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
            end
            s_memwrite: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            s_executer: begin
                state_next  = s_aluwb;
                alu_src_a_c = 2'b10;
                alu_op      = 2'b10;
            end
            s_executei: begin
                state_next  = s_aluwb;
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op      = 2'b10;
            end
            s_aluwb: begin
                reg_write_c = 1'b1;
            end
            s_jal: begin
                state_next  = s_aluwb;
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_update   = 1'b1;
            end
            s_beq: begin
                alu_src_a_c = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
            end
            default: state_next = s_fetch;
        endcase
    end

    always_comb begin
        bus.alu_control = 3'b000;
        case (alu_op)
            2'b01: bus.alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alu_control = 3'b101;
                    3'b110:  bus.alu_control = 3'b011;
                    3'b111:  bus.alu_control = 3'b010;
                    default: bus.alu_control = 3'b000;
                endcase
            end
            default: bus.alu_control = 3'b000;
        endcase
    end

    always_comb begin
        bus.imm_src = 2'b00;
        case (bus.op)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    // Reset masks every enable immediately, without waiting for the edge.
    assign bus.pc_write   = ~reset & (pc_update | (branch & bus.zero));
    assign bus.mem_write  = ~reset & mem_write_c;
    assign bus.ir_write   = ~reset & ir_write_c;
    assign bus.reg_write  = ~reset & reg_write_c;
    assign bus.illegal_op = ~reset & (state == s_decode) & op_illegal;
    assign bus.adr_src    = adr_src_c;
    assign bus.result_src = result_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle expected outputs for each
// instruction class, plus hand sequences for reset-in-MEMWRITE and illegal op.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       ill;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    multicycle_ctrl_if #(.STATE_W(4)) bus ();
    multicycle_ctrl #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.st   = bus.state_o;
        o.pcw  = bus.pc_write;
        o.adr  = bus.adr_src;
        o.mw   = bus.mem_write;
        o.irw  = bus.ir_write;
        o.rw   = bus.reg_write;
        o.rs   = bus.result_src;
        o.asa  = bus.alu_src_a;
        o.asb  = bus.alu_src_b;
        o.imm  = bus.imm_src;
        o.aluc = bus.alu_control;
        o.ill  = bus.illegal_op;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic z, input int st, input logic pcw,
                                input logic adr, input logic mw, input logic irw, input logic rw,
                                input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] imm, input logic [2:0] aluc, input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
        v.exp = '{st[3:0], pcw, adr, mw, irw, rw, rs, asa, asb, imm, aluc, ill};
        return v;
    endfunction

    task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
        @(posedge clk);
        #1;
        reset = r; bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        @(negedge clk);
    endtask

    initial begin
        int ill_count;
        reset = 1'b1; bus.op = LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;

        // lw: reset held two cycles, then 0,1,2,3,4
        vecs.push_back(mk(1, LW, 3'b010, 0, 0,  0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(1, LW, 3'b010, 0, 0,  0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0,  2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0,  3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        vecs.push_back(mk(0, LW, 3'b010, 0, 0,  4, 0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000,0));
        // sw: 0,1,2,5
        vecs.push_back(mk(0, SW, 3'b010, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0,  2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0));
        vecs.push_back(mk(0, SW, 3'b010, 0, 0,  5, 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        // beq taken, then not taken
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 1,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 1,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 1, 10, 1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0));
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
        vecs.push_back(mk(0, BEQ, 3'b000, 0, 0, 10, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0));
        // R-type sub
        vecs.push_back(mk(0, RT, 3'b000, 1, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0,  6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001,0));
        vecs.push_back(mk(0, RT, 3'b000, 1, 0,  8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // R-type or
        vecs.push_back(mk(0, RT, 3'b110, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b110, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b110, 0, 0,  6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b011,0));
        vecs.push_back(mk(0, RT, 3'b110, 0, 0,  8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // R-type slt
        vecs.push_back(mk(0, RT, 3'b010, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b010, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, RT, 3'b010, 0, 0,  6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b101,0));
        vecs.push_back(mk(0, RT, 3'b010, 0, 0,  8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // addi with funct7b5 set must stay add
        vecs.push_back(mk(0, IA, 3'b000, 1, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, IA, 3'b000, 1, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, IA, 3'b000, 1, 0,  7, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
        vecs.push_back(mk(0, IA, 3'b000, 1, 0,  8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // jal: 0,1,9,8
        vecs.push_back(mk(0, JAL, 3'b000, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b11,3'b000,0));
        vecs.push_back(mk(0, JAL, 3'b000, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11,3'b000,0));
        vecs.push_back(mk(0, JAL, 3'b000, 0, 0,  9, 1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11,3'b000,0));
        vecs.push_back(mk(0, JAL, 3'b000, 0, 0,  8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11,3'b000,0));
        // unsupported opcode: 0,1(illegal),0
        vecs.push_back(mk(0, LUI, 3'b000, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(mk(0, LUI, 3'b000, 0, 0,  1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,1));
        vecs.push_back(mk(0, LUI, 3'b000, 0, 0,  0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
        end

        // Reset arriving while in MEMWRITE
        step(1, SW, 3'b010, 0, 0);
        for (int i = 0; i < 8 && bus.state_o != 4'd5; i++) step(0, SW, 3'b010, 0, 0);
        check("reach_memwrite", 32'(bus.state_o), 32'd5);
        check("memwrite_we_before_reset", 32'(bus.mem_write), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("memwrite_we_masked", 32'(bus.mem_write), 32'd0);
        check("memwrite_state_held", 32'(bus.state_o), 32'd5);
        @(posedge clk);
        #1;
        check("state_after_reset", 32'(bus.state_o), 32'd0);

        // Illegal pulse lasts exactly one cycle over FETCH, DECODE, FETCH
        ill_count = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, LUI, 3'b000, 0, 0);
            if (bus.illegal_op === 1'b1) ill_count++;
        end
        check("illegal_pulse_cycles", 32'(ill_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle RV32I core.
- Sequences instruction execution with a Moore FSM.
- Drives the immediate-format select of the sign-extension unit, the datapath mux selects, the register/memory/IR/PC write enables and the ALU operation code.
- Sits beside the datapath; its inputs are the IR opcode fields and the ALU zero flag.

Parameters:
- STATE_W, 4, width of the state register and of the state_o debug port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruction opcode, IR[6:0].
- funct3  input  3  IR[14:12].
- funct7b5  input  1  IR[30].
- zero  input  1  ALU zero flag, same cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = Result.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  IR and OldPC load enable.
- reg_write  output  1  register file write enable.
- result_src  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rd1.
- alu_src_b  output  2  ALU B select: 00 = rd2, 01 = ImmExt, 10 = constant 4.
- imm_src  output  2  immediate format to the sign extender: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_op  output  1  one-cycle pulse: unsupported opcode seen in DECODE.
- state_o  output  STATE_W  current state, for debug only.

Behaviour:
- Synchronous reset, active high. Reset is sampled on the clk rising edge.
- Reset forces state to FETCH.
- While reset is high, all write enables and illegal_op are forced to 0 combinationally.
- After reset release, the first cycle is FETCH.

State encoding and transitions (Moore):
- FETCH=0 -> DECODE.
- DECODE=1, by op:
  - lw 0000011 or sw 0100011 -> MEMADR.
  - R-type 0110011 -> EXECUTER.
  - I-ALU 0010011 -> EXECUTEI.
  - jal 1101111 -> JAL.
  - beq 1100011 -> BEQ.
  - any other op -> FETCH, with illegal_op=1 during that DECODE cycle.
- MEMADR=2 -> MEMREAD if op=lw, else MEMWRITE.
- MEMREAD=3 -> MEMWB.
- MEMWB=4 -> FETCH.
- MEMWRITE=5 -> FETCH.
- EXECUTER=6 -> ALUWB.
- EXECUTEI=7 -> ALUWB.
- ALUWB=8 -> FETCH.
- JAL=9 -> ALUWB.
- BEQ=10 -> FETCH.
- Undefined codes 11-15 -> FETCH on the next edge. All enables are 0 while in an undefined code.

Per-state outputs (unlisted outputs are 0 / 00):
- FETCH: ir_write=1, pc_update=1, alu_src_b=10, result_src=10, alu_op=00.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target).
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWRITE: adr_src=1, mem_write=1.
- MEMWB: result_src=01, reg_write=1.
- EXECUTER: alu_src_a=10, alu_op=10.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, pc_update=1.
- BEQ: alu_src_a=10, alu_op=01, branch=1.

PC write:
- pc_write = pc_update OR (branch AND zero).
- Combinational from state and zero; no register stage.

imm_src:
- Decoded combinationally from op in every state.
- lw / I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.

alu_control (alu_op is internal):
- alu_op 00 -> add.
- alu_op 01 -> sub.
- alu_op 10, by funct3:
  - 000 -> sub if op[5] AND funct7b5, else add.
  - 010 -> slt.
  - 110 -> or.
  - 111 -> and.
  - other -> add.
- alu_op 11 -> add.

Latency per instruction class:
- lw 5 cycles.
- sw 4.
- R / I 4.
- jal 4.
- beq 3.
- illegal 2.

Test Plan:
- Reset held 2 cycles, then released with op=lw (0000011) -> state sequence 0,1,2,3,4,0. mem_write=0 throughout. reg_write=1 only in state 4. adr_src=1 in state 3. imm_src=00.
- op=sw (0100011) -> states 0,1,2,5,0. mem_write=1 only in state 5. imm_src=01. reg_write never 1.
- op=beq (1100011) -> in BEQ: zero=1 gives pc_write=1; zero=0 gives pc_write=0. alu_control=001 and imm_src=10 in both runs.
- op=0110011, funct3=000, funct7b5=1 in EXECUTER -> alu_control=001. With funct3=110 -> 011. With funct3=010 -> 101. op=0010011, funct3=000, funct7b5=1 in EXECUTEI -> 000.
- op=jal (1101111) -> states 0,1,9,8,0. pc_write=1 in FETCH and JAL. imm_src=11. reg_write=1 in ALUWB.
- op=0110111 (unsupported) -> illegal_op=1 for exactly the DECODE cycle, then FETCH. Separately, reset asserted while in MEMWRITE -> mem_write=0 that cycle and state=0 after the edge.
